// File: rtl/dmem_responder_if.sv
// Load/store port bundle between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory with a fixed wait-state access and valid/ready response.
// Define DMEM_OBS_EN to add a combinational debug read port (obs_addr/obs_data).
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   dmem_responder_if.slave  bus
`ifdef DMEM_OBS_EN
   ,
   input  logic [31:0]      obs_addr,
   output logic [31:0]      obs_data
`endif
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        lat_we;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;

   logic [31:0] mem [DEPTH_WORDS];

   logic             acc_err;
   logic             access;
   logic [IDX_W-1:0] idx;

   assign acc_err = (lat_addr[1:0] != 2'b00) ||
                    ({2'b00, lat_addr[31:2]} >= 32'(DEPTH_WORDS));
   assign idx     = lat_addr[IDX_W+1:2];
   assign access  = (state == WAIT) && (cnt == 4'd0);

   assign bus.req_ready = (state == IDLE) && rst_n;

   // NOTE: the array has no reset; reset only idles the FSM, so stores already
   // committed survive and the RAM can map onto plain block memory.
   always_ff @(posedge clk) begin
      if (access && lat_we && !acc_err) begin
         mem[idx] <= lat_wdata;
      end
   end

   // NOTE: all state uses non-blocking assignments, so the load below reads the
   // array value from before this edge, never a same-edge write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= 4'd0;
         lat_we        <= 1'b0;
         lat_addr      <= 32'd0;
         lat_wdata     <= 32'd0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= 32'd0;
         bus.rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  lat_we    <= bus.req_we;
                  lat_addr  <= bus.req_addr;
                  lat_wdata <= bus.req_wdata;
                  cnt       <= 4'(WAIT_CYCLES);
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  bus.rsp_rdata <= (!acc_err && !lat_we) ? mem[idx] : 32'd0;
                  bus.rsp_err   <= acc_err;
                  bus.rsp_valid <= 1'b1;
                  state         <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.rsp_rdata <= 32'd0;
                  bus.rsp_err   <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DMEM_OBS_EN
   logic unused_obs_bits;
   assign unused_obs_bits = &{1'b0, obs_addr[1:0]};

   always_comb begin
      obs_data = 32'd0;
      if ({2'b00, obs_addr[31:2]} < 32'(DEPTH_WORDS)) begin
         obs_data = mem[obs_addr[IDX_W+1:2]];
      end
   end
`endif

endmodule
